// File: rtl/ldpc_pkg.sv
// Shared types and elaboration helpers for the LDPC encoder front end.
package ldpc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Information bits (k) for a "n,k" code-standard string; 0 if unknown.
  function automatic int unsigned code_info_bits(input string code);
    if (code == "1280,1024") return 1024;
    if (code == "2048,1024") return 1024;
    if (code == "8176,7154") return 7154;
    return 0;
  endfunction

endpackage

// File: rtl/ldpc_tag_fifo.sv
// Owner-tag FIFO: one bit per codeblock in flight inside the encoder.
module ldpc_tag_fifo
  import ldpc_pkg::*;
#(
  parameter int unsigned depth = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned ptr_w = (clog2(depth) > 0) ? clog2(depth) : 1;

  logic [depth-1:0] mem;
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == (ptr_w+1)'(depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ptr_w+1)'(push_ok) - (ptr_w+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/ldpc_frame_arbiter.sv
// Codeblock-granular round-robin arbiter sharing one LDPC encoder between two sources.
// Optional per-channel output block counters: define LDPC_ARB_FRAME_CNT_EN.
module ldpc_frame_arbiter
  import ldpc_pkg::*;
#(
  parameter int unsigned width     = 8,
  parameter int unsigned info_bits = 1024,
  parameter int unsigned tag_depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] s0_axis_tdata,
  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic [width-1:0] s1_axis_tdata,
  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  output logic [width-1:0] enc_s_axis_tdata,
  output logic             enc_s_axis_tvalid,
  input  logic             enc_s_axis_tready,
  input  logic [width-1:0] enc_m_axis_tdata,
  input  logic             enc_m_axis_tvalid,
  input  logic             enc_m_axis_tlast,
  output logic             enc_m_axis_tready,
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic             m_axis_tready,
  output logic             busy
`ifdef LDPC_ARB_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt0,
  output logic [15:0]      frame_cnt1
`endif
);

  localparam int unsigned beats = info_bits / width;
  localparam int unsigned cnt_w = (clog2(beats) > 0) ? clog2(beats) : 1;

  // A block must be a whole number of beats and the tag FIFO a power of two.
  if ((info_bits % width) != 0 || info_bits < width) begin : g_bad_info_bits
    $fatal(1, "ldpc_frame_arbiter: info_bits must be a non-zero multiple of width");
  end
  if (tag_depth < 2 || (tag_depth & (tag_depth - 1)) != 0) begin : g_bad_tag_depth
    $fatal(1, "ldpc_frame_arbiter: tag_depth must be a power of two >= 2");
  end

  state_t           state;
  logic             sel;
  logic             last_grant;
  logic [cnt_w-1:0] beat_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic             grant;
  logic             grant_ch;
  logic             enc_hs;
  logic             pop;
  logic             xfer;

  assign xfer     = (state == ST_XFER);
  assign grant    = ~xfer & ~fifo_full & (s0_axis_tvalid | s1_axis_tvalid);
  // On a tie the channel that did not win last time goes next.
  assign grant_ch = (s0_axis_tvalid & s1_axis_tvalid) ? ~last_grant : s1_axis_tvalid;

  assign enc_s_axis_tdata  = sel ? s1_axis_tdata : s0_axis_tdata;
  assign enc_s_axis_tvalid = xfer & (sel ? s1_axis_tvalid : s0_axis_tvalid);
  assign s0_axis_tready    = xfer & ~sel & enc_s_axis_tready;
  assign s1_axis_tready    = xfer &  sel & enc_s_axis_tready;
  assign enc_hs            = enc_s_axis_tvalid & enc_s_axis_tready;
  assign busy              = xfer;

  // Encoder output is held off while no owner tag is available.
  assign m_axis_tdata      = enc_m_axis_tdata;
  assign m_axis_tlast      = enc_m_axis_tlast;
  assign m_axis_tvalid     = enc_m_axis_tvalid & ~fifo_empty;
  assign enc_m_axis_tready = m_axis_tready & ~fifo_empty;
  assign m_axis_tuser      = fifo_head;
  assign pop               = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            sel   <= grant_ch;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (enc_hs) begin
            if (beat_cnt == cnt_w'(beats - 1)) begin
              beat_cnt   <= '0;
              last_grant <= sel;
              state      <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ldpc_tag_fifo #(.depth(tag_depth)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (grant_ch),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

`ifdef LDPC_ARB_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else if (pop) begin
      if (fifo_head) frame_cnt1 <= frame_cnt1 + 16'd1;
      else           frame_cnt0 <= frame_cnt0 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ldpc_frame_arbiter.sv
// Directed bench for ldpc_frame_arbiter with a 128-in / 160-out encoder model.
module tb_ldpc_frame_arbiter;

  localparam int unsigned W      = 8;
  localparam int unsigned BEATS  = 128;
  localparam int unsigned OBEATS = 160;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s0_axis_tdata, s1_axis_tdata;
  logic         s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
  logic         s0_axis_tready, s1_axis_tready;
  logic [W-1:0] enc_s_axis_tdata;
  logic         enc_s_axis_tvalid;
  logic         enc_s_axis_tready = 1'b1;
  logic [W-1:0] enc_m_axis_tdata;
  logic         enc_m_axis_tvalid, enc_m_axis_tlast, enc_m_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic         m_axis_tready = 1'b1;
  logic         busy;
`ifdef LDPC_ARB_FRAME_CNT_EN
  logic [15:0]  frame_cnt0, frame_cnt1;
`endif

  logic clr = 1'b1;
  logic inject = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ldpc_frame_arbiter #(.width(W), .info_bits(1024), .tag_depth(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .enc_s_axis_tdata(enc_s_axis_tdata), .enc_s_axis_tvalid(enc_s_axis_tvalid),
    .enc_s_axis_tready(enc_s_axis_tready),
    .enc_m_axis_tdata(enc_m_axis_tdata), .enc_m_axis_tvalid(enc_m_axis_tvalid),
    .enc_m_axis_tlast(enc_m_axis_tlast), .enc_m_axis_tready(enc_m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .busy(busy)
`ifdef LDPC_ARB_FRAME_CNT_EN
    , .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1)
`endif
  );

  // Encoder model: absorbs 128-beat blocks, emits 160-beat blocks with tlast on the last.
  int  in_cnt = 0, pending = 0, out_beat = 0;
  logic enc_in_hs, enc_out_hs, enc_out_last;
  assign enc_in_hs         = enc_s_axis_tvalid & enc_s_axis_tready;
  assign enc_out_last      = (out_beat == OBEATS - 1);
  assign enc_out_hs        = (pending != 0) & enc_m_axis_tready;
  assign enc_m_axis_tvalid = (pending != 0) | inject;
  assign enc_m_axis_tlast  = (pending != 0) & enc_out_last;
  assign enc_m_axis_tdata  = out_beat[W-1:0];

  always @(posedge clk) begin
    if (!rst_n) begin
      in_cnt   <= 0;
      pending  <= 0;
      out_beat <= 0;
    end else begin
      if (enc_in_hs) in_cnt <= (in_cnt == BEATS - 1) ? 0 : in_cnt + 1;
      if (enc_out_hs) out_beat <= enc_out_last ? 0 : out_beat + 1;
      pending <= pending + ((enc_in_hs && in_cnt == BEATS - 1) ? 1 : 0)
                         - ((enc_out_hs && enc_out_last) ? 1 : 0);
    end
  end

  // Monitor: handshake counts, completed-block order, output tags, idle gaps.
  int hs0 = 0, hs1 = 0, hs_enc = 0, ob = 0, blk_len = 0;
  int gap = 0, min_gap = 999, max_gap = 0;
  logic seen = 1'b0, s0r_seen = 1'b0, s1r_seen = 1'b0;
  int grant_q[$];
  int out_q[$];

  assign s0_axis_tdata = hs0[W-1:0];
  assign s1_axis_tdata = hs1[W-1:0] ^ 8'h80;

  always @(posedge clk) begin
    if (clr) begin
      hs0 <= 0; hs1 <= 0; hs_enc <= 0; ob <= 0; blk_len <= 0;
      gap <= 0; min_gap <= 999; max_gap <= 0;
      seen <= 1'b0; s0r_seen <= 1'b0; s1r_seen <= 1'b0;
      grant_q.delete();
      out_q.delete();
    end else begin
      if (s0_axis_tvalid && s0_axis_tready) begin
        hs0 <= hs0 + 1;
        if (hs0 % BEATS == BEATS - 1) grant_q.push_back(0);
      end
      if (s1_axis_tvalid && s1_axis_tready) begin
        hs1 <= hs1 + 1;
        if (hs1 % BEATS == BEATS - 1) grant_q.push_back(1);
      end
      if (enc_in_hs) hs_enc <= hs_enc + 1;
      if (s0_axis_tready) s0r_seen <= 1'b1;
      if (s1_axis_tready) s1r_seen <= 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (m_axis_tlast) begin
          out_q.push_back(int'(m_axis_tuser));
          blk_len <= ob + 1;
          ob <= 0;
        end else begin
          ob <= ob + 1;
        end
      end
      if (busy) begin
        if (seen && gap > 0) begin
          if (gap < min_gap) min_gap <= gap;
          if (gap > max_gap) max_gap <= gap;
        end
        gap  <= 0;
        seen <= 1'b1;
      end else if (seen) begin
        gap <= gap + 1;
      end
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr   = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr   = 1'b0;
  endtask

  initial begin
    // 1: single source block
    do_reset();
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_s0_ready", s0_axis_tready, 0);
    expect_eq("rst_s1_ready", s1_axis_tready, 0);
    expect_eq("rst_enc_valid", enc_s_axis_tvalid, 0);
    expect_eq("rst_m_valid", m_axis_tvalid, 0);
    s0_axis_tvalid = 1'b1;
    @(negedge clk);
    expect_eq("t1_grant_busy", busy, 1);
    expect_eq("t1_grant_s0_ready", s0_axis_tready, 1);
    expect_eq("t1_enc_data", enc_s_axis_tdata, s0_axis_tdata);
    for (int t = 0; t < 400 && hs0 < BEATS; t++) @(negedge clk);
    expect_eq("t1_busy_fall", busy, 0);
    s0_axis_tvalid = 1'b0;
    for (int t = 0; t < 600 && out_q.size() < 1; t++) @(negedge clk);
    expect_eq("t1_beats", hs0, BEATS);
    expect_eq("t1_enc_beats", hs_enc, BEATS);
    expect_eq("t1_s1_ready_seen", s1r_seen, 0);
    expect_eq("t1_out_blocks", out_q.size(), 1);
    expect_eq("t1_tuser", (out_q.size() > 0) ? out_q[0] : 9, 0);
    expect_eq("t1_tlast_beat", blk_len, OBEATS);

    // 2: both sources continuously valid from reset
    s0_axis_tvalid = 1'b1;
    s1_axis_tvalid = 1'b1;
    do_reset();
    for (int t = 0; t < 1000 && grant_q.size() < 4; t++) @(negedge clk);
    s0_axis_tvalid = 1'b0;
    s1_axis_tvalid = 1'b0;
    for (int t = 0; t < 1200 && out_q.size() < 4; t++) @(negedge clk);
    expect_eq("t2_blocks", grant_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      expect_eq($sformatf("t2_grant%0d", i), (i < grant_q.size()) ? grant_q[i] : 9, 32'(i % 2));
      expect_eq($sformatf("t2_tuser%0d", i), (i < out_q.size()) ? out_q[i] : 9, 32'(i % 2));
    end
    expect_eq("t2_min_gap", min_gap, 1);
    expect_eq("t2_max_gap", max_gap, 1);

    // 3: output stalled, FIFO fills after four grants
    m_axis_tready = 1'b0;
    s0_axis_tvalid = 1'b1;
    s1_axis_tvalid = 1'b1;
    do_reset();
    for (int t = 0; t < 1000 && grant_q.size() < 4; t++) @(negedge clk);
    repeat (20) @(negedge clk);
    expect_eq("t3_grants", grant_q.size(), 4);
    expect_eq("t3_enc_beats", hs_enc, 4 * BEATS);
    expect_eq("t3_full_busy", busy, 0);
    expect_eq("t3_full_s0_ready", s0_axis_tready, 0);
    expect_eq("t3_full_s1_ready", s1_axis_tready, 0);
    m_axis_tready = 1'b1;
    for (int t = 0; t < 400 && out_q.size() < 1; t++) @(negedge clk);
    m_axis_tready = 1'b0;
    expect_eq("t3_release_tuser", (out_q.size() > 0) ? out_q[0] : 9, 0);
    for (int t = 0; t < 10 && !busy; t++) @(negedge clk);
    expect_eq("t3_fifth_grant", busy, 1);
    s0_axis_tvalid = 1'b0;
    s1_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // 4: selected source stalls mid-block; no regrant
    do_reset();
    s1_axis_tvalid = 1'b1;
    for (int t = 0; t < 200 && hs1 < 50; t++) @(negedge clk);
    s1_axis_tvalid = 1'b0;
    s0_axis_tvalid = 1'b1;
    repeat (10) @(negedge clk);
    expect_eq("t4_stall_busy", busy, 1);
    expect_eq("t4_stall_beats", hs1, 50);
    s1_axis_tvalid = 1'b1;
    for (int t = 0; t < 200 && hs1 < BEATS; t++) @(negedge clk);
    s0_axis_tvalid = 1'b0;
    s1_axis_tvalid = 1'b0;
    expect_eq("t4_s0_ready_seen", s0r_seen, 0);
    expect_eq("t4_s1_beats", hs1, BEATS);
    expect_eq("t4_enc_beats", hs_enc, BEATS);
    expect_eq("t4_s0_beats", hs0, 0);

    // 5: reset mid-block, then a lone s1 block
    do_reset();
    s0_axis_tvalid = 1'b1;
    for (int t = 0; t < 200 && hs0 < 64; t++) @(negedge clk);
    rst_n  = 1'b0;
    inject = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    expect_eq("t5_rst_s0_ready", s0_axis_tready, 0);
    expect_eq("t5_rst_busy", busy, 0);
    expect_eq("t5_empty_m_valid", m_axis_tvalid, 0);
    expect_eq("t5_empty_enc_ready", enc_m_axis_tready, 0);
    s0_axis_tvalid = 1'b0;
    inject = 1'b0;
    s1_axis_tvalid = 1'b1;
    @(negedge clk);
    expect_eq("t5_s1_grant", s1_axis_tready, 1);
    for (int t = 0; t < 200 && hs1 < BEATS; t++) @(negedge clk);
    s1_axis_tvalid = 1'b0;
    for (int t = 0; t < 600 && out_q.size() < 1; t++) @(negedge clk);
    expect_eq("t5_out_blocks", out_q.size(), 1);
    expect_eq("t5_tuser", (out_q.size() > 0) ? out_q[0] : 9, 1);

`ifdef LDPC_ARB_FRAME_CNT_EN
    // 6: per-channel block counters and wrap
    s0_axis_tvalid = 1'b1;
    s1_axis_tvalid = 1'b1;
    do_reset();
    for (int t = 0; t < 1000 && grant_q.size() < 4; t++) @(negedge clk);
    s1_axis_tvalid = 1'b0;
    for (int t = 0; t < 1000 && grant_q.size() < 5; t++) @(negedge clk);
    s0_axis_tvalid = 1'b0;
    for (int t = 0; t < 2000 && out_q.size() < 5; t++) @(negedge clk);
    expect_eq("t6_cnt0", frame_cnt0, 3);
    expect_eq("t6_cnt1", frame_cnt1, 2);
    force dut.frame_cnt0 = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt0;
    s0_axis_tvalid = 1'b1;
    for (int t = 0; t < 400 && grant_q.size() < 6; t++) @(negedge clk);
    s0_axis_tvalid = 1'b0;
    for (int t = 0; t < 600 && out_q.size() < 6; t++) @(negedge clk);
    expect_eq("t6_cnt0_wrap", frame_cnt0, 0);
    expect_eq("t6_cnt1_hold", frame_cnt1, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
